// File: rtl/mcts_backprop.sv
// MCTS backprop walker: pops the node-path stack leaf first and
// updates per-node visit/score counters with alternating perspective.
// Ports: clk, reset, start, result, stack_empty, stack_data in;
// stack_read, busy, done, nodes_updated, err out; rd_addr in with
// rd_visits/rd_score out as a combinational host read port.
module mcts_backprop #(
  parameter int NODE_W = 10,
  parameter int NODE_COUNT = 64,
  parameter int STAT_W = 16,
  localparam int AW = $clog2(NODE_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        result,
  input  logic              stack_empty,
  input  logic [NODE_W-1:0] stack_data,
  output logic              stack_read,
  output logic              busy,
  output logic              done,
  output logic [NODE_W-1:0] nodes_updated,
  output logic              err,
  input  logic [AW-1:0]     rd_addr,
  output logic [STAT_W-1:0] rd_visits,
  output logic [STAT_W-1:0] rd_score
);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, UPDATE, DONE
  } state_e;

  state_e state_q, state_d;
  logic [1:0] res_q, res_d;
  logic persp_q, persp_d;
  logic [NODE_W-1:0] idx_q, idx_d;
  logic [NODE_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;

  logic [STAT_W-1:0] visits_q [NODE_COUNT];
  logic [STAT_W-1:0] score_q [NODE_COUNT];

  logic in_range;
  logic wr_en;
  logic [AW-1:0] waddr;
  logic win, loss;
  logic [1:0] pts;
  logic [STAT_W:0] v_sum, s_sum;
  logic [STAT_W-1:0] v_d, s_d;

  assign in_range = idx_q < NODE_W'(NODE_COUNT);
  assign waddr = idx_q[AW-1:0];
  assign wr_en = (state_q == UPDATE) && in_range;

  // persp_q=1 is the opponent's view: win and loss trade places
  always_comb begin
    win  = (res_q == 2'b01);
    loss = (res_q == 2'b10);
    if (persp_q) begin
      win  = (res_q == 2'b10);
      loss = (res_q == 2'b01);
    end
    pts = win ? 2'd2 : (loss ? 2'd0 : 2'd1);
  end

  // one extra bit catches overflow for saturation
  always_comb begin
    v_sum = {1'b0, visits_q[waddr]} + (STAT_W+1)'(1);
    s_sum = {1'b0, score_q[waddr]}
          + {{(STAT_W-1){1'b0}}, pts};
    v_d = v_sum[STAT_W] ? '1 : v_sum[STAT_W-1:0];
    s_d = s_sum[STAT_W] ? '1 : s_sum[STAT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    persp_d    = persp_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    stack_read = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          res_d   = result;
          persp_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = POP;
        end
      end
      POP: begin
        if (stack_empty) begin
          state_d = DONE;
        end else begin
          stack_read = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        idx_d   = stack_data;
        cnt_d   = cnt_q + 1'b1;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (!in_range) err_d = 1'b1;
        persp_d = ~persp_q;
        state_d = POP;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= 2'b00;
      persp_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      persp_q <= persp_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NODE_COUNT; i++) begin
        visits_q[i] <= '0;
        score_q[i]  <= '0;
      end
    end else if (wr_en) begin
      visits_q[waddr] <= v_d;
      score_q[waddr]  <= s_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign nodes_updated = cnt_q;
  assign err           = err_q;
  assign rd_visits     = visits_q[rd_addr];
  assign rd_score      = score_q[rd_addr];

endmodule

// File: tb/tb_mcts_backprop.sv
// Bench for mcts_backprop: stack model, scoreboard on done,
// table reference model and randomized passes.
module tb_mcts_backprop;

  localparam int NW = 10;
  localparam int NC = 64;
  localparam int SW = 8;
  localparam int MAXV = (1 << SW) - 1;

  typedef struct {
    int n;
    bit e;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] result = 2'b00;
  logic stack_empty = 1'b1;
  logic [NW-1:0] stack_data = '0;
  logic stack_read;
  logic busy;
  logic done;
  logic [NW-1:0] nodes_updated;
  logic err;
  logic [5:0] rd_addr = '0;
  logic [SW-1:0] rd_visits;
  logic [SW-1:0] rd_score;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stk[$];
  exp_t sb[$];
  int mv[NC];
  int ms[NC];

  mcts_backprop #(
    .NODE_W(NW), .NODE_COUNT(NC), .STAT_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .result(result), .stack_empty(stack_empty),
    .stack_data(stack_data), .stack_read(stack_read),
    .busy(busy), .done(done),
    .nodes_updated(nodes_updated), .err(err),
    .rd_addr(rd_addr), .rd_visits(rd_visits),
    .rd_score(rd_score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LIFO stack: data appears the cycle after a pop
  always @(posedge clk) begin
    int n;
    n = stk.size();
    if (stack_read && n > 0) begin
      stack_data <= NW'(stk[n-1]);
      stk.pop_back();
      n = n - 1;
    end
    stack_empty <= (n == 0);
  end

  // monitor: pop expectation on every done pulse
  always @(negedge clk) begin
    exp_t x;
    if (!reset && stack_read) begin
      total++;
      if (stack_empty) begin
        bad++;
        $display("FAIL read_when_empty cyc=%0d", cyc);
      end
    end
    if (!reset && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        x = sb.pop_front();
        if (int'(nodes_updated) != (x.n % 1024) ||
            err !== x.e || cyc != x.cyc) begin
          bad++;
          $display("FAIL done_chk got n=%0d e=%0b cyc=%0d exp n=%0d e=%0b cyc=%0d",
                   nodes_updated, err, cyc,
                   x.n % 1024, x.e, x.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got,
                     input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  task automatic check_table();
    for (int a = 0; a < NC; a++) begin
      rd_addr = 6'(a);
      #1;
      total++;
      if (int'(rd_visits) != mv[a] || int'(rd_score) != ms[a]) begin
        bad++;
        $display("FAIL table[%0d] got v=%0d s=%0d exp v=%0d s=%0d",
                 a, rd_visits, rd_score, mv[a], ms[a]);
      end
    end
  endtask

  task automatic check_one(input int a, input int ev,
                           input int es);
    rd_addr = 6'(a);
    #1;
    chk($sformatf("visits[%0d]", a), int'(rd_visits), ev);
    chk($sformatf("score[%0d]", a), int'(rd_score), es);
  endtask

  // nodes[0] is the bottom of the stack; last element is the leaf
  task automatic run_pass(input int nodes[$],
                          input logic [1:0] r,
                          input bit spur);
    exp_t x;
    int n;
    int id;
    bit w, l, t;
    int p;
    n = nodes.size();
    @(negedge clk);
    foreach (nodes[i]) stk.push_back(nodes[i]);
    x.n = n;
    x.e = 1'b0;
    for (int i = 0; i < n; i++) begin
      id = nodes[n-1-i];
      w = (r == 2'b01);
      l = (r == 2'b10);
      if (i % 2 == 1) begin
        t = w; w = l; l = t;
      end
      p = w ? 2 : (l ? 0 : 1);
      if (id >= NC) begin
        x.e = 1'b1;
      end else begin
        mv[id] = (mv[id] + 1 > MAXV) ? MAXV : mv[id] + 1;
        ms[id] = (ms[id] + p > MAXV) ? MAXV : ms[id] + p;
      end
    end
    x.cyc = cyc + 3 * n + 2;
    sb.push_back(x);
    start = 1'b1;
    result = r;
    @(negedge clk);
    start = 1'b0;
    result = 2'($urandom);
    if (spur) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      result = ~r;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 3 * n + 30 && sb.size() != 0; k++)
      @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout got=none exp=done");
      sb.delete();
    end
    @(negedge clk);
    check_table();
  endtask

  initial begin
    int q[$];
    foreach (mv[i]) begin
      mv[i] = 0;
      ms[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("busy_rst", int'(busy), 0);
    chk("read_rst", int'(stack_read), 0);
    chk("nodes_rst", int'(nodes_updated), 0);
    chk("err_rst", int'(err), 0);
    check_table();

    q = '{3, 7, 12};
    run_pass(q, 2'b01, 1'b0);
    check_one(12, 1, 2);
    check_one(7, 1, 0);
    check_one(3, 1, 2);
    chk("nodes_3", int'(nodes_updated), 3);

    q = '{5, 9};
    run_pass(q, 2'b00, 1'b0);
    run_pass(q, 2'b10, 1'b0);
    check_one(9, 2, 1);
    check_one(5, 2, 3);

    q = {};
    run_pass(q, 2'b01, 1'b0);
    chk("nodes_empty", int'(nodes_updated), 0);

    q = '{20, 21, 22};
    run_pass(q, 2'b01, 1'b1);

    q = '{70};
    run_pass(q, 2'b01, 1'b0);
    chk("err_oor", int'(err), 1);
    chk("nodes_oor", int'(nodes_updated), 1);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(0, 6);
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back($urandom_range(0, 79));
      run_pass(q, 2'($urandom), ($urandom_range(0, 3) == 0) && len >= 2);
    end

    q = {};
    for (int i = 0; i < 300; i++) q.push_back(4);
    run_pass(q, 2'b01, 1'b0);
    check_one(4, MAXV, MAXV);

    q = '{30, 31};
    @(negedge clk);
    foreach (q[i]) stk.push_back(q[i]);
    start = 1'b1;
    result = 2'b01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    stk.delete();
    @(negedge clk);
    chk("busy_midrst", int'(busy), 0);
    chk("nodes_midrst", int'(nodes_updated), 0);
    reset = 1'b0;
    foreach (mv[i]) begin
      mv[i] = 0;
      ms[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("busy_after", int'(busy), 0);
    check_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcts_backprop.md
# mcts_backprop

Backpropagation walker for the MCTS datapath. It sits directly downstream of the node-path stack, which holds the node indices pushed during selection. After a rollout finishes, this block pops every index off the stack, leaf first. For each node it updates an internal visit/score table, alternating the result's perspective at each tree level, and it exposes the table to the host through a combinational read port.

## Interface
- NODE_W, 10: node index width; matches stack data width.
- NODE_COUNT, 64: stats table entries; valid indices 0..NODE_COUNT-1.
- STAT_W, 16: width of the visit and score counters.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a backprop pass; ignored while busy.
- result  in  2  leaf outcome from the leaf player's view: 01 win, 10 loss, 00 draw, 11 treated as draw. Sampled on start.
- stack_empty  in  1  stack reports zero entries.
- stack_data  in  NODE_W  stack output; valid the cycle after stack_read.
- stack_read  out  1  pop request to the stack, at most one cycle per node.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the stack is drained.
- nodes_updated  out  NODE_W  count of indices popped this pass; holds until the next start.
- err  out  1  sticky; set on an out-of-range index; cleared by reset or start.
- rd_addr  in  $clog2(NODE_COUNT)  host read address.
- rd_visits  out  STAT_W  visits[rd_addr], combinational.
- rd_score  out  STAT_W  score[rd_addr], combinational; half-points.

## Operation
- States: IDLE, POP, LOAD, UPDATE, DONE.
- IDLE: on start, do the following and go to POP.
  - Latch result.
  - Set perspective to leaf.
  - Clear nodes_updated and err.
- POP:
  - If stack_empty, go to DONE with stack_read low.
  - Otherwise drive stack_read=1 for this cycle only and go to LOAD.
- LOAD:
  - Capture stack_data into idx.
  - Increment nodes_updated, wrapping at 2^NODE_W.
  - Go to UPDATE.
- UPDATE:
  - If idx < NODE_COUNT:
    - visits[idx] += 1, saturating at 2^STAT_W-1.
    - score[idx] += pts, saturating.
  - Otherwise leave the table untouched and set err.
  - Toggle perspective and go to POP.
- pts, from result seen through the current perspective:
  - Win: 2. Draw: 1. Loss: 0.
  - At leaf perspective, result is used as-is.
  - At the toggled perspective, win and loss are swapped.
- DONE: done=1 for one cycle, then IDLE.
- A start pulse outside IDLE is ignored and does not alter the latched result.
- start arriving with the stack already empty takes the path IDLE, POP, DONE; done asserts 2 cycles after start and nodes_updated=0.
- The host read port reads the table only and never stalls the FSM. A read of the entry being written this cycle returns the old value.

## Timing
- Reset values:
  - Outputs: state IDLE, stack_read=0, busy=0, done=0, nodes_updated=0, err=0.
  - Internal: all visits and score entries 0, perspective=leaf.
- Reset mid-pass returns to IDLE the next cycle with no further table writes. The stack must be reset in the same cycle.
- Per node: 3 cycles (POP, LOAD, UPDATE), so stack_read pulses are spaced 3 cycles apart.
- The table write takes effect at the clock edge that ends UPDATE.
- For N nodes, done asserts 3N+2 cycles after the start edge.
- stack_empty is sampled only in POP. It has settled by then because the previous pop occurred 3 cycles earlier.
- stack_read is never asserted while stack_empty=1.

## Test plan
- Reset: after reset, rd_visits=0 and rd_score=0 for all 64 addresses; busy=0 and stack_read=0.
- Three-node win:
  - Stimulus: stack holds 3,7,12 (12 on top), result=01.
  - Pop order: 12, 7, 3.
  - Expected: visits[12]=visits[7]=visits[3]=1; score[12]=2, score[7]=0, score[3]=2.
  - done asserts 11 cycles after start; nodes_updated=3.
- Draw then loss:
  - Stimulus: first pass with stack 5,9 (9 on top), result=00; second pass with the same stack, result=10.
  - Expected: visits[9]=visits[5]=2; score[9]=1, score[5]=3.
- Empty stack: start with stack_empty=1 gives done 2 cycles later, no stack_read and nodes_updated=0. A start during busy is ignored.
- Out of range: stack holds 70, result=01. Expected: err=1, table unchanged, done still asserts, nodes_updated=1.
- Saturation and reset:
  - Preload visits[4]=0xFFFF, then run one pass over node 4: visits stays 0xFFFF.
  - Assert reset during LOAD: busy=0 next cycle and no write to the table.
